// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
//   WORD_W    : datapath width
//   REG_W     : architectural register index width
//   aluop_t   : ALU operation code (ALU_SLL is the all-zero idle value)
//   alusrc_t  : ALU B-operand source select (encoding 3 behaves as SRC_REG)
//   regbits_t : register index
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_NOR  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } aluop_t;

    typedef enum logic [1:0] {
        SRC_REG   = 2'd0,
        SRC_IMM   = 2'd1,
        SRC_SHAMT = 2'd2
    } alusrc_t;

    typedef logic [REG_W-1:0] regbits_t;

    // rs feeds the A operand for every source select except shift-by-shamt.
    function automatic logic src_uses_rs(input alusrc_t src);
        return src != SRC_SHAMT;
    endfunction

    // rt is read unless B comes from the immediate (encoding 3 decodes as SRC_REG).
    function automatic logic src_uses_rt(input alusrc_t src);
        return src != SRC_IMM;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one source register.
//   idx_i                      : source register index
//   stored_i                   : operand value held in the issue slot
//   exm_regwen_i/exm_memread_i : EX/MEM producer writes a register / is a load
//   exm_wsel_i/exm_wdat_i      : EX/MEM destination and result
//   wb_regwen_i/wb_wsel_i/wb_wdat_i : MEM/WB writeback bus
//   fwd_o                      : forwarded operand
module fwd_mux #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic [REG_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] stored_i,
    input  logic              exm_regwen_i,
    input  logic              exm_memread_i,
    input  logic [REG_W-1:0]  exm_wsel_i,
    input  logic [WORD_W-1:0] exm_wdat_i,
    input  logic              wb_regwen_i,
    input  logic [REG_W-1:0]  wb_wsel_i,
    input  logic [WORD_W-1:0] wb_wdat_i,
    output logic [WORD_W-1:0] fwd_o
);

    logic idx_nz;
    logic exm_hit;
    logic wb_hit;

    always_comb begin
        idx_nz  = (idx_i != '0);
        // A load's EX/MEM result is an address, not data; it must not be forwarded.
        exm_hit = exm_regwen_i & ~exm_memread_i & (exm_wsel_i == idx_i) & idx_nz;
        wb_hit  = wb_regwen_i & (wb_wsel_i == idx_i) & idx_nz;

        fwd_o = stored_i;
        if (!idx_nz) begin
            fwd_o = '0;
        end else if (exm_hit) begin
            fwd_o = exm_wdat_i;
        end else if (wb_hit) begin
            fwd_o = wb_wdat_i;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue register feeding the ALU.
// Holds one decoded instruction until the execute stage takes it, forwards register
// operands from EX/MEM and MEM/WB, inserts the load-use bubble and handles flush.
//   CLK, RST       : clock; synchronous active-high reset
//   flush          : kill the held instruction and refuse the current offer
//   id_*           : decoded instruction offer with valid/ready handshake
//   exm_*          : EX/MEM producer bus (forwarding and load-use detection)
//   wb_*           : MEM/WB writeback bus (forwarding and held-operand refresh)
//   ex_*           : ALU op/operands plus destination passthrough, valid/ready handshake
module alu_issue
    import cpu_types_pkg::aluop_t;
    import cpu_types_pkg::alusrc_t;
#(
    parameter int unsigned WORD_W = cpu_types_pkg::WORD_W,
    parameter int unsigned REG_W  = cpu_types_pkg::REG_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,

    input  logic              id_valid,
    output logic              id_ready,
    input  aluop_t            id_aluop,
    input  alusrc_t           id_src,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [WORD_W-1:0] id_rsdat,
    input  logic [WORD_W-1:0] id_rtdat,
    input  logic [WORD_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [REG_W-1:0]  id_wsel,
    input  logic              id_regwen,

    input  logic              exm_regwen,
    input  logic              exm_memread,
    input  logic [REG_W-1:0]  exm_wsel,
    input  logic [WORD_W-1:0] exm_wdat,

    input  logic              wb_regwen,
    input  logic [REG_W-1:0]  wb_wsel,
    input  logic [WORD_W-1:0] wb_wdat,

    output logic              ex_valid,
    input  logic              ex_ready,
    output aluop_t            ex_aluop,
    output logic [WORD_W-1:0] ex_a,
    output logic [WORD_W-1:0] ex_b,
    output logic [REG_W-1:0]  ex_wsel,
    output logic              ex_regwen
);

    // Slot state.
    logic              v_q,      v_d;
    aluop_t            aluop_q,  aluop_d;
    alusrc_t           src_q,    src_d;
    logic [REG_W-1:0]  rs_q,     rs_d;
    logic [REG_W-1:0]  rt_q,     rt_d;
    logic [WORD_W-1:0] rsdat_q,  rsdat_d;
    logic [WORD_W-1:0] rtdat_q,  rtdat_d;
    logic [WORD_W-1:0] imm_q,    imm_d;
    logic [4:0]        shamt_q,  shamt_d;
    logic [REG_W-1:0]  wsel_q,   wsel_d;
    logic              regwen_q, regwen_d;

    logic              acc;
    logic              luh;
    logic              fire;
    logic [WORD_W-1:0] fwd_rs;
    logic [WORD_W-1:0] fwd_rt;

    // WB bus writes register idx (never r0).
    function automatic logic wb_writes(input logic [REG_W-1:0] idx);
        return wb_regwen & (wb_wsel == idx) & (idx != '0);
    endfunction

    fwd_mux #(
        .WORD_W (WORD_W),
        .REG_W  (REG_W)
    ) u_fwd_rs (
        .idx_i         (rs_q),
        .stored_i      (rsdat_q),
        .exm_regwen_i  (exm_regwen),
        .exm_memread_i (exm_memread),
        .exm_wsel_i    (exm_wsel),
        .exm_wdat_i    (exm_wdat),
        .wb_regwen_i   (wb_regwen),
        .wb_wsel_i     (wb_wsel),
        .wb_wdat_i     (wb_wdat),
        .fwd_o         (fwd_rs)
    );

    fwd_mux #(
        .WORD_W (WORD_W),
        .REG_W  (REG_W)
    ) u_fwd_rt (
        .idx_i         (rt_q),
        .stored_i      (rtdat_q),
        .exm_regwen_i  (exm_regwen),
        .exm_memread_i (exm_memread),
        .exm_wsel_i    (exm_wsel),
        .exm_wdat_i    (exm_wdat),
        .wb_regwen_i   (wb_regwen),
        .wb_wsel_i     (wb_wsel),
        .wb_wdat_i     (wb_wdat),
        .fwd_o         (fwd_rt)
    );

    // Handshake and hazard detection.
    always_comb begin
        // A load in EX/MEM cannot forward yet; stall if it targets an operand in use.
        luh = v_q & exm_regwen & exm_memread & (exm_wsel != '0) &
              ((cpu_types_pkg::src_uses_rs(src_q) & (exm_wsel == rs_q)) |
               (cpu_types_pkg::src_uses_rt(src_q) & (exm_wsel == rt_q)));

        // Reset forces both handshakes low during the reset cycle itself.
        ex_valid = ~RST & v_q & ~luh & ~flush;
        fire     = ex_valid & ex_ready;
        id_ready = ~RST & ~flush & (~v_q | fire);
        acc      = id_valid & id_ready;
    end

    // Operand selection and passthrough outputs.
    always_comb begin
        ex_aluop  = aluop_q;
        ex_wsel   = wsel_q;
        ex_regwen = regwen_q;
        ex_a      = fwd_rs;
        ex_b      = fwd_rt;
        unique case (src_q)
            cpu_types_pkg::SRC_IMM: begin
                ex_b = imm_q;
            end
            cpu_types_pkg::SRC_SHAMT: begin
                ex_a       = fwd_rt;
                ex_b       = '0;
                ex_b[4:0]  = shamt_q;
            end
            default: begin
                // SRC_REG and the unused encoding 3.
                ex_b = fwd_rt;
            end
        endcase
    end

    // Next-state.
    always_comb begin
        v_d      = v_q;
        aluop_d  = aluop_q;
        src_d    = src_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rsdat_d  = rsdat_q;
        rtdat_d  = rtdat_q;
        imm_d    = imm_q;
        shamt_d  = shamt_q;
        wsel_d   = wsel_q;
        regwen_d = regwen_q;

        if (acc) begin
            aluop_d  = id_aluop;
            src_d    = id_src;
            rs_d     = id_rs;
            rt_d     = id_rt;
            imm_d    = id_imm;
            shamt_d  = id_shamt;
            wsel_d   = id_wsel;
            regwen_d = id_regwen;
            // The register file read misses a same-cycle writeback; patch it in.
            rsdat_d  = wb_writes(id_rs) ? wb_wdat : id_rsdat;
            rtdat_d  = wb_writes(id_rt) ? wb_wdat : id_rtdat;
        end else begin
            // Absorb retiring producers so a long stall never loses their data.
            if (wb_writes(rs_q)) begin
                rsdat_d = wb_wdat;
            end
            if (wb_writes(rt_q)) begin
                rtdat_d = wb_wdat;
            end
        end

        if (flush) begin
            v_d = 1'b0;
        end else if (acc) begin
            v_d = 1'b1;
        end else if (fire) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v_q      <= 1'b0;
            aluop_q  <= cpu_types_pkg::ALU_SLL;
            src_q    <= cpu_types_pkg::SRC_REG;
            rs_q     <= '0;
            rt_q     <= '0;
            rsdat_q  <= '0;
            rtdat_q  <= '0;
            imm_q    <= '0;
            shamt_q  <= '0;
            wsel_q   <= '0;
            regwen_q <= 1'b0;
        end else begin
            v_q      <= v_d;
            aluop_q  <= aluop_d;
            src_q    <= src_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rsdat_q  <= rsdat_d;
            rtdat_q  <= rtdat_d;
            imm_q    <= imm_d;
            shamt_q  <= shamt_d;
            wsel_q   <= wsel_d;
            regwen_q <= regwen_d;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios followed by randomized traffic,
// all compared cycle by cycle against a behavioural model of the issue slot.
module tb_alu_issue;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, flush;
    logic        id_valid, id_ready;
    aluop_t      id_aluop;
    alusrc_t     id_src;
    logic [4:0]  id_rs, id_rt, id_shamt, id_wsel;
    logic [31:0] id_rsdat, id_rtdat, id_imm;
    logic        id_regwen;
    logic        exm_regwen, exm_memread;
    logic [4:0]  exm_wsel;
    logic [31:0] exm_wdat;
    logic        wb_regwen;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        ex_valid, ex_ready;
    aluop_t      ex_aluop;
    logic [31:0] ex_a, ex_b;
    logic [4:0]  ex_wsel;
    logic        ex_regwen;

    alu_issue #(.WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_aluop(id_aluop), .id_src(id_src),
        .id_rs(id_rs), .id_rt(id_rt), .id_rsdat(id_rsdat), .id_rtdat(id_rtdat),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_wsel(id_wsel), .id_regwen(id_regwen),
        .exm_regwen(exm_regwen), .exm_memread(exm_memread), .exm_wsel(exm_wsel),
        .exm_wdat(exm_wdat), .wb_regwen(wb_regwen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_aluop(ex_aluop), .ex_a(ex_a),
        .ex_b(ex_b), .ex_wsel(ex_wsel), .ex_regwen(ex_regwen)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: the held instruction as a record.
    typedef struct {
        bit          v;
        aluop_t      op;
        int          kind;   // 0 reg, 1 imm, 2 shamt
        logic [4:0]  rs, rt, shamt, wsel;
        logic [31:0] rsd, rtd, imm;
        logic        regwen;
    } slot_t;

    slot_t m;
    logic        e_valid, e_ready;
    logic [31:0] e_a, e_b;

    function automatic int kind_of(input alusrc_t s);
        if (s == SRC_IMM) return 1;
        if (s == SRC_SHAMT) return 2;
        return 0;
    endfunction

    // Value register r holds as seen by the ALU this cycle.
    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] held);
        if (r == 0) return 32'h0;
        if (exm_regwen && !exm_memread && exm_wsel == r) return exm_wdat;
        if (wb_regwen && wb_wsel == r) return wb_wdat;
        return held;
    endfunction

    task automatic model_reset();
        m = '{v: 0, op: ALU_SLL, kind: 0, rs: 0, rt: 0, shamt: 0, wsel: 0,
              rsd: 0, rtd: 0, imm: 0, regwen: 0};
    endtask

    task automatic model_eval();
        bit reads_rs, reads_rt, stall;
        reads_rs = (m.kind != 2);
        reads_rt = (m.kind != 1);
        stall = m.v && exm_regwen && exm_memread && exm_wsel != 0 &&
                ((reads_rs && exm_wsel == m.rs) || (reads_rt && exm_wsel == m.rt));
        e_valid = !RST && m.v && !stall && !flush;
        e_ready = !RST && !flush && (!m.v || (ex_ready && e_valid));
        case (m.kind)
            1:       begin e_a = m_fwd(m.rs, m.rsd); e_b = m.imm; end
            2:       begin e_a = m_fwd(m.rt, m.rtd); e_b = {27'h0, m.shamt}; end
            default: begin e_a = m_fwd(m.rs, m.rsd); e_b = m_fwd(m.rt, m.rtd); end
        endcase
    endtask

    task automatic model_update();
        bit take;
        if (RST) begin
            model_reset();
            return;
        end
        take = id_valid && e_ready;
        if (take) begin
            m.op = id_aluop; m.kind = kind_of(id_src); m.rs = id_rs; m.rt = id_rt;
            m.shamt = id_shamt; m.wsel = id_wsel; m.imm = id_imm; m.regwen = id_regwen;
            m.rsd = (wb_regwen && wb_wsel == id_rs && id_rs != 0) ? wb_wdat : id_rsdat;
            m.rtd = (wb_regwen && wb_wsel == id_rt && id_rt != 0) ? wb_wdat : id_rtdat;
        end else begin
            if (wb_regwen && wb_wsel == m.rs && m.rs != 0) m.rsd = wb_wdat;
            if (wb_regwen && wb_wsel == m.rt && m.rt != 0) m.rtd = wb_wdat;
        end
        if (flush) m.v = 0;
        else if (take) m.v = 1;
        else if (e_valid && ex_ready) m.v = 0;
    endtask

    task automatic sample();
        @(negedge CLK);
        model_eval();
        check_eq("ex_valid", 32'(ex_valid), 32'(e_valid));
        check_eq("id_ready", 32'(id_ready), 32'(e_ready));
        if (m.v) begin
            check_eq("ex_aluop", 32'(ex_aluop), 32'(m.op));
            check_eq("ex_a", ex_a, e_a);
            check_eq("ex_b", ex_b, e_b);
            check_eq("ex_wsel", 32'(ex_wsel), 32'(m.wsel));
            check_eq("ex_regwen", 32'(ex_regwen), 32'(m.regwen));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic buses_idle();
        exm_regwen = 0; exm_memread = 0; exm_wsel = 0; exm_wdat = 0;
        wb_regwen = 0; wb_wsel = 0; wb_wdat = 0;
    endtask

    task automatic offer(input aluop_t op, input alusrc_t src, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic [4:0] sh, input logic [4:0] wsel);
        id_valid = 1; id_aluop = op; id_src = src; id_rs = rs; id_rt = rt;
        id_rsdat = rsd; id_rtdat = rtd; id_imm = imm; id_shamt = sh;
        id_wsel = wsel; id_regwen = 1;
    endtask

    initial begin
        model_reset();
        RST = 1; flush = 0; ex_ready = 1; buses_idle();
        offer(ALU_ADD, SRC_REG, 0, 0, 0, 0, 0, 0, 0);
        id_valid = 0;

        // Reset state.
        sample();
        check_eq("rst_id_ready", 32'(id_ready), 0);
        tick();
        sample(); tick();
        RST = 0;
        sample();
        check_eq("rst_aluop", 32'(ex_aluop), 32'(ALU_SLL));
        check_eq("rst_a", ex_a, 0);
        check_eq("rst_b", ex_b, 0);
        check_eq("rst_wsel", 32'(ex_wsel), 0);
        check_eq("rst_regwen", 32'(ex_regwen), 0);
        tick();

        // Streaming, back-to-back.
        offer(ALU_ADD, SRC_REG, 1, 2, 5, 7, 0, 0, 3);
        sample(); check_eq("stream_ready0", 32'(id_ready), 1); tick();
        offer(ALU_SUB, SRC_REG, 4, 5, 9, 11, 0, 0, 6);
        sample();
        check_eq("stream_a0", ex_a, 5); check_eq("stream_b0", ex_b, 7);
        check_eq("stream_op0", 32'(ex_aluop), 32'(ALU_ADD));
        check_eq("stream_ready1", 32'(id_ready), 1);
        tick();
        id_valid = 0;
        sample(); check_eq("stream_v1", 32'(ex_valid), 1); check_eq("stream_a1", ex_a, 9);
        tick();

        // EX/MEM priority and r0 WB non-forward.
        offer(ALU_ADD, SRC_IMM, 1, 0, 32'h77, 0, 3, 0, 2);
        ex_ready = 0;
        sample(); tick();
        id_valid = 0;
        wb_regwen = 1; wb_wsel = 0; wb_wdat = 32'h20;
        sample(); check_eq("wb_r0_nofwd", ex_a, 32'h77); tick();
        exm_regwen = 1; exm_wsel = 1; exm_wdat = 32'h10; wb_wsel = 1;
        sample(); check_eq("exm_priority", ex_a, 32'h10); tick();
        buses_idle(); ex_ready = 1;
        sample(); check_eq("held_from_wb", ex_a, 32'h20); tick();

        // Load-use bubble then WB forward.
        offer(ALU_ADD, SRC_REG, 1, 2, 1, 0, 0, 0, 3);
        sample(); tick();
        id_valid = 0;
        exm_regwen = 1; exm_memread = 1; exm_wsel = 2;
        sample(); check_eq("luh_bubble", 32'(ex_valid), 0); tick();
        buses_idle(); wb_regwen = 1; wb_wsel = 2; wb_wdat = 32'hBEEF;
        sample(); check_eq("luh_issue", 32'(ex_valid), 1); check_eq("luh_b", ex_b, 32'hBEEF);
        tick();
        buses_idle();
        offer(ALU_SLL, SRC_SHAMT, 2, 3, 0, 1, 0, 4, 5);
        sample(); tick();
        id_valid = 0;
        exm_regwen = 1; exm_memread = 1; exm_wsel = 2;
        sample();
        check_eq("sll_nostall", 32'(ex_valid), 1);
        check_eq("sll_a", ex_a, 1); check_eq("sll_b", ex_b, 4);
        tick();
        buses_idle();

        // Held operand refresh across a 3-cycle stall.
        offer(ALU_ADD, SRC_REG, 4, 0, 1, 0, 0, 0, 7);
        sample(); tick();
        id_valid = 0; ex_ready = 0;
        wb_regwen = 1; wb_wsel = 4; wb_wdat = 32'h99;
        sample(); tick();
        buses_idle();
        sample(); tick();
        sample(); tick();
        ex_ready = 1;
        sample(); check_eq("refresh_a", ex_a, 32'h99); tick();

        // Immediate select.
        offer(ALU_ADD, SRC_IMM, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 8);
        sample(); tick();
        id_valid = 0;
        sample(); check_eq("imm_b", ex_b, 32'hFFFFFFFF); tick();

        // Flush beats accept.
        offer(ALU_OR, SRC_REG, 1, 1, 3, 3, 0, 0, 9);
        flush = 1;
        sample(); check_eq("flush_ready", 32'(id_ready), 0); tick();
        flush = 0; id_valid = 0;
        sample(); check_eq("flush_noissue", 32'(ex_valid), 0); tick();

        // Reset mid-stall.
        offer(ALU_XOR, SRC_REG, 1, 2, 32'h55, 32'h66, 0, 0, 10);
        ex_ready = 0;
        sample(); tick();
        id_valid = 0;
        sample(); check_eq("stall_valid", 32'(ex_valid), 1); tick();
        RST = 1;
        sample(); tick();
        RST = 0;
        sample();
        check_eq("midrst_valid", 32'(ex_valid), 0);
        check_eq("midrst_a", ex_a, 0);
        check_eq("midrst_regwen", 32'(ex_regwen), 0);
        tick();

        // Randomized traffic with a narrow register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            RST         = ($urandom_range(0, 63) == 0);
            flush       = ($urandom_range(0, 15) == 0);
            ex_ready    = ($urandom_range(0, 3) != 0);
            id_valid    = $urandom_range(0, 1);
            id_aluop    = aluop_t'($urandom_range(0, 10));
            id_src      = alusrc_t'($urandom_range(0, 3));
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_rsdat    = $urandom;
            id_rtdat    = $urandom;
            id_imm      = $urandom;
            id_shamt    = 5'($urandom);
            id_wsel     = 5'($urandom);
            id_regwen   = $urandom_range(0, 1);
            exm_regwen  = $urandom_range(0, 1);
            exm_memread = ($urandom_range(0, 2) == 0);
            exm_wsel    = 5'($urandom_range(0, 3));
            exm_wdat    = $urandom;
            wb_regwen   = $urandom_range(0, 1);
            wb_wsel     = 5'($urandom_range(0, 3));
            wb_wdat     = $urandom;
            sample();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
